// File: rtl/hdu_pkg.sv
// hdu_pkg: shared definitions for the hazard-detection scoreboard.
//   - LEGv8 opcode values used by the decoder
//   - slot_t: one tracked in-flight destination {valid, dest, is_load}
//   - fsm_t:  flush state machine states
//   - is_rtype(): true for the register-register ALU opcodes the unit decodes
package hdu_pkg;

   localparam int unsigned FIELD_W = 5;

   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_ORR  = 11'h550;
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   localparam logic [7:0]  OP_CBZ  = 8'hB4;
   localparam logic [5:0]  OP_B    = 6'h05;

   typedef struct packed {
      logic               valid;
      logic [FIELD_W-1:0] dest;
      logic               is_load;
   } slot_t;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fsm_t;

   function automatic logic is_rtype(input logic [10:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
   endfunction

endpackage

// File: rtl/hdu_decode.sv
// hdu_decode: combinational source/destination decode of the IF/ID instruction.
// Ports:
//   instr      in   32  instruction held in IF/ID
//   rn         out  5   Rn field [9:5]
//   rm_rt      out  5   second source: Rm [20:16] for R-type, Rt [4:0] otherwise
//   use_rn     out  1   rn is read by this instruction
//   use_rm_rt  out  1   rm_rt is read by this instruction
//   dest       out  5   destination field (Rd/Rt) [4:0]
//   writes     out  1   instruction writes a register
//   is_load    out  1   instruction is LDUR
module hdu_decode
   import hdu_pkg::*;
(
   input  logic [31:0]        instr,
   output logic [FIELD_W-1:0] rn,
   output logic [FIELD_W-1:0] rm_rt,
   output logic               use_rn,
   output logic               use_rm_rt,
   output logic [FIELD_W-1:0] dest,
   output logic               writes,
   output logic               is_load
);

   logic [10:0] op_s;

   assign op_s = instr[31:21];

   // Opcode classification into register usage
   always_comb begin
      rn        = instr[9:5];
      rm_rt     = instr[4:0];
      dest      = instr[4:0];
      use_rn    = 1'b0;
      use_rm_rt = 1'b0;
      writes    = 1'b0;
      is_load   = 1'b0;
      if (is_rtype(op_s)) begin
         rm_rt     = instr[20:16];
         use_rn    = 1'b1;
         use_rm_rt = 1'b1;
         writes    = 1'b1;
      end else if (op_s == OP_LDUR) begin
         use_rn  = 1'b1;
         writes  = 1'b1;
         is_load = 1'b1;
      end else if (op_s == OP_STUR) begin
         // Store reads both the base (Rn) and the data register (Rt)
         use_rn    = 1'b1;
         use_rm_rt = 1'b1;
      end else if (instr[31:24] == OP_CBZ) begin
         use_rm_rt = 1'b1;
      end else if (instr[31:26] == OP_B) begin
         // Unconditional branch reads no registers
         use_rn    = 1'b0;
      end else begin
         use_rn    = 1'b0;
      end
   end

endmodule

// File: rtl/hdu_scoreboard.sv
// hdu_scoreboard: sequential hazard-detection unit for the 5-stage LEGv8 pipeline.
// Tracks destinations of instructions in flight after ID, raises load-use/RAW
// stalls for the IF/ID instruction and multi-cycle flushes on taken branches.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   if_id_valid       IF/ID holds a real instruction
//   if_id_instr       instruction in IF/ID
//   branch_taken_mem  branch resolved taken in MEM this cycle
//   pc_write_en       0 = hold PC
//   if_id_write_en    0 = hold IF/ID
//   id_ex_bubble      1 = load NOP into ID/EX
//   flush_if_id/id_ex/ex_mem  clear the respective pipeline register
//   hazard_detected   RAW stall this cycle
//   hazard_reg        conflicting source index (0 when none)
//   stall_count       saturating count of stall cycles
//   flush_count       saturating count of taken-branch events
module hdu_scoreboard
   import hdu_pkg::*;
#(
   parameter int REG_W        = 32'sd5,
   parameter int DEPTH        = 32'sd2,
   parameter int FORWARDING   = 32'sd1,
   parameter int FLUSH_CYCLES = 32'sd1,
   parameter int CNT_W        = 32'sd16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_id_valid,
   input  logic [31:0]      if_id_instr,
   input  logic             branch_taken_mem,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic             id_ex_bubble,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             hazard_detected,
   output logic [REG_W-1:0] hazard_reg,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int              FC_W    = $clog2(FLUSH_CYCLES + 32'sd1);
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);
   localparam logic [REG_W-1:0] XZR    = {REG_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [FIELD_W-1:0] dec_rn_s;
   logic [FIELD_W-1:0] dec_rm_rt_s;
   logic [FIELD_W-1:0] dec_dest_s;
   logic               dec_use_rn_s;
   logic               dec_use_rm_rt_s;
   logic               dec_writes_s;
   logic               dec_is_load_s;

   slot_t              slot_r [DEPTH];
   slot_t              new_entry_s;
   logic               rn_hit_s;
   logic               rm_hit_s;
   logic               flush_active_s;
   logic               stall_s;

   fsm_t               state_r;
   fsm_t               state_nxt_s;
   logic [FC_W-1:0]    fc_r;
   logic [FC_W-1:0]    fc_nxt_s;
   logic [CNT_W-1:0]   stall_cnt_r;
   logic [CNT_W-1:0]   flush_cnt_r;

   hdu_decode u_decode (
      .instr     (if_id_instr),
      .rn        (dec_rn_s),
      .rm_rt     (dec_rm_rt_s),
      .use_rn    (dec_use_rn_s),
      .use_rm_rt (dec_use_rm_rt_s),
      .dest      (dec_dest_s),
      .writes    (dec_writes_s),
      .is_load   (dec_is_load_s)
   );

   // Entry that would enter slot0 on a normal edge; XZR writes are never tracked
   always_comb begin
      new_entry_s.valid   = dec_writes_s & if_id_valid & (REG_W'(dec_dest_s) != XZR);
      new_entry_s.dest    = dec_dest_s;
      new_entry_s.is_load = dec_is_load_s;
   end

   // Source-vs-slot comparators; with forwarding only a load in slot0 can stall
   always_comb begin
      rn_hit_s = 1'b0;
      rm_hit_s = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         logic elig;
         elig = slot_r[k].valid & if_id_valid &
                ((FORWARDING == 32'sd0) | ((k == 32'sd0) & slot_r[k].is_load));
         rn_hit_s = rn_hit_s | (elig & dec_use_rn_s    & (slot_r[k].dest == dec_rn_s));
         rm_hit_s = rm_hit_s | (elig & dec_use_rm_rt_s & (slot_r[k].dest == dec_rm_rt_s));
      end
   end

   // A flush in progress (or starting now) overrides any stall
   assign flush_active_s = branch_taken_mem | (state_r == FLUSH);
   assign stall_s        = (rn_hit_s | rm_hit_s) & ~flush_active_s;

   assign pc_write_en     = ~stall_s;
   assign if_id_write_en  = ~stall_s;
   assign id_ex_bubble    = stall_s;
   assign hazard_detected = stall_s;
   assign flush_if_id     = flush_active_s;
   assign flush_id_ex     = flush_active_s;
   assign flush_ex_mem    = flush_active_s;
   assign stall_count     = stall_cnt_r;
   assign flush_count     = flush_cnt_r;

   // Report Rn first when both sources conflict
   always_comb begin
      if (!stall_s) begin
         hazard_reg = '0;
      end else if (rn_hit_s) begin
         hazard_reg = REG_W'(dec_rn_s);
      end else begin
         hazard_reg = REG_W'(dec_rm_rt_s);
      end
   end

   // Flush FSM next state; a new taken branch reloads the down-counter
   always_comb begin
      state_nxt_s = state_r;
      fc_nxt_s    = fc_r;
      case (state_r)
         RUN: begin
            if (branch_taken_mem) begin
               state_nxt_s = FLUSH;
               fc_nxt_s    = FC_LOAD;
            end else begin
               state_nxt_s = RUN;
            end
         end
         FLUSH: begin
            if (branch_taken_mem) begin
               fc_nxt_s = FC_LOAD;
            end else if (fc_r <= FC_W'(1'b1)) begin
               state_nxt_s = RUN;
               fc_nxt_s    = '0;
            end else begin
               fc_nxt_s = fc_r - FC_W'(1'b1);
            end
         end
         default: begin
            state_nxt_s = RUN;
            fc_nxt_s    = '0;
         end
      endcase
   end

   // Flush FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= RUN;
         fc_r    <= '0;
      end else begin
         state_r <= state_nxt_s;
         fc_r    <= fc_nxt_s;
      end
   end

   // In-flight slot shift register: flush clears all, stall inserts a bubble
   always_ff @(posedge clk) begin
      if (reset || flush_active_s) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_r[k] <= '0;
         end
      end else begin
         slot_r[0] <= stall_s ? slot_t'('0) : new_entry_s;
         for (int k = 1; k < DEPTH; k++) begin
            slot_r[k] <= slot_r[k-1];
         end
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (branch_taken_mem && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1'b1);
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

endmodule
